// File: rtl/regfile_arb_pkg.sv
// Shared types and widths for the register-file debug arbiter.
package regfile_arb_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } dbg_req_t;

endpackage

// File: rtl/regfile_dbg_arbiter_sat_counter.sv
// Saturating up-counter; used for the optional stall statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates regfile ports between the core (priority) and a debug requester.
// Optional REGFILE_ARB_STATS_EN adds a saturating stall_cnt output.
//
//   state | meaning
//   IDLE  | no debug op in flight, dbg_ready=1
//   PEND  | request latched; write waits for an idle core write port
//   STALL | ports stolen for one cycle, core frozen
module regfile_dbg_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_reg_wr,
    input  logic [REG_AW-1:0] core_waddr,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic [REG_AW-1:0] core_raddr1,
    input  logic [REG_AW-1:0] core_raddr2,
    output logic [XLEN-1:0]   core_rdata1,
    output logic [XLEN-1:0]   core_rdata2,
    output logic              core_stall,
    output logic              rf_reg_wr,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              dbg_valid,
    output logic              dbg_ready,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
    output logic              dbg_done,
    output logic [XLEN-1:0]   dbg_rdata
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    // A starved write sees MAX_WAIT-1 PEND cycles; the last one moves to STALL.
    localparam logic [WAIT_W-1:0] STALL_AT = WAIT_W'((MAX_WAIT > 1) ? (MAX_WAIT - 2) : 0);

    arb_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    dbg_req_t          req;
    logic              commit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            req       <= '0;
            dbg_done  <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == IDLE && dbg_valid)
                req <= '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};
            dbg_done <= commit || (state == STALL);
            if (state == STALL && !req.we)
                dbg_rdata <= rf_rdata2;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_valid)
                    state_nxt = PEND;
            end
            PEND: begin
                if (!req.we) begin
                    state_nxt = STALL;
                end else if (!core_reg_wr) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_cnt >= STALL_AT)
                        state_nxt = STALL;
                end
            end
            STALL: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
            default: begin
                state_nxt = IDLE;
                wait_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        rf_reg_wr  = core_reg_wr;
        rf_waddr   = core_waddr;
        rf_wdata   = core_wdata;
        rf_raddr1  = core_raddr1;
        rf_raddr2  = core_raddr2;
        core_stall = 1'b0;
        dbg_ready  = (state == IDLE);
        if (commit || (state == STALL && req.we)) begin
            rf_reg_wr = 1'b1;
            rf_waddr  = req.addr;
            rf_wdata  = req.wdata;
        end
        if (state == STALL) begin
            core_stall = 1'b1;
            if (!req.we) begin
                rf_reg_wr = 1'b0;
                rf_raddr2 = req.addr;
            end
        end
    end

    assign core_rdata1 = rf_rdata1;
    assign core_rdata2 = rf_rdata2;

`ifdef REGFILE_ARB_STATS_EN
    sat_counter #(.W(16)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (state == STALL),
        .count (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Directed bench for regfile_dbg_arbiter with a negedge-write regfile model (xN = N<<8 on reset).
module tb_regfile_dbg_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_reg_wr = 1'b0;
    logic [4:0]  core_waddr = '0;
    logic [31:0] core_wdata = '0;
    logic [4:0]  core_raddr1 = '0;
    logic [4:0]  core_raddr2 = '0;
    logic [31:0] core_rdata1, core_rdata2;
    logic        core_stall;
    logic        rf_reg_wr;
    logic [4:0]  rf_waddr, rf_raddr1, rf_raddr2;
    logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_done;
    logic [31:0] dbg_rdata;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    regfile_dbg_arbiter dut (
        .clk(clk), .reset(reset),
        .core_reg_wr(core_reg_wr), .core_waddr(core_waddr), .core_wdata(core_wdata),
        .core_raddr1(core_raddr1), .core_raddr2(core_raddr2),
        .core_rdata1(core_rdata1), .core_rdata2(core_rdata2), .core_stall(core_stall),
        .rf_reg_wr(rf_reg_wr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata)
`ifdef REGFILE_ARB_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] rf [32];
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i) << 8;
        end else if (rf_reg_wr && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        core_raddr1 = 5'd3; core_raddr2 = 5'd4; core_reg_wr = 1'b1; core_waddr = 5'd9; core_wdata = 32'h900;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0h want 1", dbg_ready); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0h want 0", core_stall); end
        checks++; if (dbg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0h want 0", dbg_done); end
        checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", dbg_rdata); end
        checks++; if (rf_raddr1 !== 5'd3) begin errors++; $display("FAIL pass_raddr1: got %0d want 3", rf_raddr1); end
        checks++; if (core_rdata1 !== 32'h300) begin errors++; $display("FAIL pass_rdata1: got %h want 300", core_rdata1); end
        checks++; if (core_rdata2 !== 32'h400) begin errors++; $display("FAIL pass_rdata2: got %h want 400", core_rdata2); end
        checks++; if (rf_reg_wr !== 1'b1 || rf_waddr !== 5'd9) begin errors++; $display("FAIL pass_write: got we=%0h a=%0d want we=1 a=9", rf_reg_wr, rf_waddr); end
        core_reg_wr = 1'b0;
    endtask

    task automatic test_write_idle();
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %0h want 1", dbg_ready); end
        clk_edge();
        dbg_valid = 1'b0; dbg_wdata = 32'h0;
        #1;
        checks++; if (rf_reg_wr !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wr_commit: got we=%0h a=%0d d=%h want 1/5/deadbeef", rf_reg_wr, rf_waddr, rf_wdata); end
        checks++; if (core_stall !== 1'b0 || dbg_ready !== 1'b0 || dbg_done !== 1'b0) begin
            errors++; $display("FAIL wr_pend_flags: got stall=%0h ready=%0h done=%0h want 0/0/0", core_stall, dbg_ready, dbg_done); end
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b1) begin errors++; $display("FAIL wr_done: got %0h want 1", dbg_done); end
        checks++; if (rf[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_x5: got %h want deadbeef", rf[5]); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL wr_nostall: got %0h want 0", core_stall); end
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %0h want 0", dbg_done); end
    endtask

    task automatic test_read();
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd2;
        clk_edge();
        dbg_valid = 1'b0; dbg_addr = 5'd0;
        #1;
        checks++; if (core_stall !== 1'b0 || dbg_done !== 1'b0) begin errors++; $display("FAIL rd_pend: got stall=%0h done=%0h want 0/0", core_stall, dbg_done); end
        clk_edge();
        core_reg_wr = 1'b1; core_waddr = 5'd11; core_wdata = 32'hBAD; core_raddr2 = 5'd6;
        #1;
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rd_stall: got %0h want 1", core_stall); end
        checks++; if (rf_reg_wr !== 1'b0 || rf_raddr2 !== 5'd2) begin errors++; $display("FAIL rd_ports: got we=%0h ra2=%0d want 0/2", rf_reg_wr, rf_raddr2); end
        clk_edge();
        core_reg_wr = 1'b0;
        #1;
        checks++; if (dbg_done !== 1'b1 || dbg_rdata !== 32'h200) begin errors++; $display("FAIL rd_done: got done=%0h rdata=%h want 1/200", dbg_done, dbg_rdata); end
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL rd_unstall: got %0h want 0", core_stall); end
        checks++; if (rf[11] !== 32'hB00) begin errors++; $display("FAIL rd_core_wr_dropped: got %h want b00", rf[11]); end
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b0 || dbg_rdata !== 32'h200) begin errors++; $display("FAIL rd_hold: got done=%0h rdata=%h want 0/200", dbg_done, dbg_rdata); end
    endtask

    task automatic test_starved_write();
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h77;
        core_reg_wr = 1'b1; core_waddr = 5'd9; core_wdata = 32'h99;
        for (int i = 0; i < 7; i++) begin
            clk_edge();
            dbg_valid = 1'b0;
            #1;
            checks++; if (core_stall !== 1'b0 || rf_waddr !== 5'd9) begin
                errors++; $display("FAIL starve_pend%0d: got stall=%0h wa=%0d want 0/9", i, core_stall, rf_waddr); end
        end
        clk_edge();
        core_waddr = 5'd10; core_wdata = 32'hBAD;
        #1;
        checks++; if (core_stall !== 1'b1 || rf_reg_wr !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin
            errors++; $display("FAIL starve_stall: got stall=%0h we=%0h a=%0d d=%h want 1/1/7/77", core_stall, rf_reg_wr, rf_waddr, rf_wdata); end
        clk_edge();
        core_reg_wr = 1'b0;
        #1;
        checks++; if (dbg_done !== 1'b1) begin errors++; $display("FAIL starve_done: got %0h want 1", dbg_done); end
        checks++; if (rf[7] !== 32'h77 || rf[10] !== 32'hA00 || rf[9] !== 32'h99) begin
            errors++; $display("FAIL starve_regs: got x7=%h x10=%h x9=%h want 77/a00/99", rf[7], rf[10], rf[9]); end
    endtask

    task automatic test_busy_then_idle();
        int  pend;
        bit  seen;
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hC0FFEE;
        core_reg_wr = 1'b1; core_waddr = 5'd13; core_wdata = 32'h1313;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            dbg_valid = 1'b0;
            #1;
            checks++; if (core_stall !== 1'b0 || rf_waddr !== 5'd13) begin
                errors++; $display("FAIL busy_pend%0d: got stall=%0h wa=%0d want 0/13", i, core_stall, rf_waddr); end
        end
        clk_edge();
        core_reg_wr = 1'b0;
        #1;
        checks++; if (rf_reg_wr !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC0FFEE || core_stall !== 1'b0) begin
            errors++; $display("FAIL busy_commit: got we=%0h a=%0d d=%h stall=%0h want 1/12/c0ffee/0", rf_reg_wr, rf_waddr, rf_wdata, core_stall); end
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b1 || rf[12] !== 32'hC0FFEE) begin
            errors++; $display("FAIL busy_done: got done=%0h x12=%h want 1/c0ffee", dbg_done, rf[12]); end
        // A fresh starved write must again see the full wait before stalling.
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd14; dbg_wdata = 32'hE;
        core_reg_wr = 1'b1;
        pend = 0; seen = 1'b0;
        while (!seen && pend < 20) begin
            clk_edge();
            dbg_valid = 1'b0;
            #1;
            if (core_stall === 1'b1) seen = 1'b1;
            else pend++;
        end
        checks++; if (!seen || pend != 7) begin errors++; $display("FAIL wait_cleared: got %0d pend cycles (stall seen=%0d) want 7", pend, seen); end
        clk_edge();
        core_reg_wr = 1'b0;
        #1;
        checks++; if (dbg_done !== 1'b1 || rf[14] !== 32'hE) begin errors++; $display("FAIL wait2_done: got done=%0h x14=%h want 1/e", dbg_done, rf[14]); end
    endtask

    task automatic test_reset_in_stall();
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
        clk_edge();
        dbg_valid = 1'b0;
        clk_edge(); #1;
        checks++; if (core_stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0h want 1", core_stall); end
        reset = 1'b1;
        #1;
        checks++; if (core_stall !== 1'b0 || dbg_ready !== 1'b1 || dbg_done !== 1'b0 || dbg_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_async: got stall=%0h ready=%0h done=%0h rdata=%h want 0/1/0/0", core_stall, dbg_ready, dbg_done, dbg_rdata); end
        clk_edge();
        reset = 1'b0;
        #1;
        checks++; if (dbg_done !== 1'b0) begin errors++; $display("FAIL rst_no_done: got %0h want 0", dbg_done); end
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b0 || dbg_ready !== 1'b1) begin errors++; $display("FAIL rst_idle: got done=%0h ready=%0h want 0/1", dbg_done, dbg_ready); end
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
        clk_edge();
        dbg_valid = 1'b0;
        clk_edge();
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b1 || dbg_rdata !== 32'h400) begin errors++; $display("FAIL rst_after_read: got done=%0h rdata=%h want 1/400", dbg_done, dbg_rdata); end
    endtask

    task automatic test_x0_back_to_back();
        clk_edge();
        reset = 1'b1;
        #2 reset = 1'b0;
        clk_edge();
        dbg_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h1;
        clk_edge();
        dbg_valid = 1'b0;
        clk_edge();
        // Accept the next request in the same cycle the previous one reports done.
        dbg_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
        #1;
        checks++; if (dbg_done !== 1'b1 || dbg_ready !== 1'b1) begin errors++; $display("FAIL x0_wr_done: got done=%0h ready=%0h want 1/1", dbg_done, dbg_ready); end
        checks++; if (rf[0] !== 32'h0) begin errors++; $display("FAIL x0_kept: got %h want 0", rf[0]); end
        clk_edge();
        dbg_valid = 1'b0;
        #1;
        checks++; if (dbg_ready !== 1'b0 || dbg_done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got ready=%0h done=%0h want 0/0", dbg_ready, dbg_done); end
        clk_edge();
        clk_edge(); #1;
        checks++; if (dbg_done !== 1'b1 || dbg_rdata !== 32'h0) begin errors++; $display("FAIL x0_rd: got done=%0h rdata=%h want 1/0", dbg_done, dbg_rdata); end
`ifdef REGFILE_ARB_STATS_EN
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", stall_cnt); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write_idle();
        test_read();
        test_starved_write();
        test_busy_then_idle();
        test_reset_in_stall();
        test_x0_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
